lemmings_track_ctrl: RTL



---
 rtl/lemmings_track_ctrl_pkg.sv | 16 +
 rtl/lemming_walker.sv | 38 +++
 rtl/lemmings_track_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lemmings_track_ctrl_pkg.sv
// Shared encodings for the Lemmings track controller and its walker FSM.
package lemmings_track_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold,
    StDone
  } ctrl_state_e;

  typedef enum logic {
    DirLeft,
    DirRight
  } walk_dir_e;

endpackage

// File: rtl/lemming_walker.sv
// Two-state Lemmings walker: flips direction on bumps; force_left reseeds it for a new run.
module lemming_walker
  import lemmings_track_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic force_left,
  input  logic bump_left,
  input  logic bump_right,
  output logic walk_left,
  output logic walk_right
);

  walk_dir_e dir_q, dir_d;

  always_comb begin
    dir_d = dir_q;
    if (force_left) begin
      dir_d = DirLeft;
    end else if (bump_left) begin
      dir_d = DirRight;
    end else if (bump_right) begin
      dir_d = DirLeft;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= DirLeft;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign walk_left  = (dir_q == DirLeft);
  assign walk_right = (dir_q == DirRight);

endmodule

// File: rtl/lemmings_track_ctrl.sv
// Track controller: paces the walker with a prescaler, owns its position, generates end-of-track
// bumps and stops after a programmed number of bounces.
module lemmings_track_ctrl
  import lemmings_track_ctrl_pkg::*;
#(
  parameter int unsigned TRACK_LEN = 16,
  parameter int unsigned POS_W     = 4,
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned BOUNCE_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic [BOUNCE_W-1:0] max_bounces,
  output logic [POS_W-1:0]    pos,
  output logic                walk_left,
  output logic                walk_right,
  output logic [BOUNCE_W-1:0] bounce_cnt,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [POS_W-1:0]    POS_MAX   = POS_W'(TRACK_LEN - 1);
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(STEP_DIV - 1);
  localparam logic [BOUNCE_W-1:0] CNT_SAT   = '1;

  ctrl_state_e         state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [BOUNCE_W-1:0] cnt_q, cnt_d;
  logic [BOUNCE_W-1:0] limit_q, limit_d;
  logic [BOUNCE_W-1:0] cnt_inc;
  logic                step_tick;
  logic                bump_left;
  logic                bump_right;
  logic                force_left;

  lemming_walker u_walker (
    .clk        (clk),
    .reset      (reset),
    .force_left (force_left),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .walk_left  (walk_left),
    .walk_right (walk_right)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    step_tick  = 1'b0;
    bump_left  = 1'b0;
    bump_right = 1'b0;
    force_left = 1'b0;
    cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pos_d      = '0;
          presc_d    = '0;
          cnt_d      = '0;
          limit_d    = max_bounces;
          force_left = 1'b1;
          state_d    = (max_bounces == '0) ? StDone : StRun;
        end
      end
      // HOLD differs from RUN only in that pause was high last edge; an un-paused HOLD cycle
      // counts like a RUN cycle, so a P-cycle pause delays everything by exactly P.
      StRun, StHold: begin
        if (pause) begin
          state_d = StHold;
        end else begin
          state_d = StRun;
          if (presc_q == PRESC_MAX) begin
            presc_d   = '0;
            step_tick = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (step_tick) begin
            if (walk_left && (pos_q == '0)) begin
              bump_left = 1'b1;
            end else if (walk_right && (pos_q == POS_MAX)) begin
              bump_right = 1'b1;
            end else if (walk_left) begin
              pos_d = pos_q - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
            if (bump_left || bump_right) begin
              cnt_d = cnt_inc;
              if (cnt_inc == limit_q) begin
                state_d = StDone;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pos_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign pos        = pos_q;
  assign bounce_cnt = cnt_q;
  assign busy       = (state_q == StRun) || (state_q == StHold);
  assign done       = (state_q == StDone);

endmodule
